// File: rtl/tdc_echo_packer_pkg.sv
// Shared record layout, field widths and FSM encoding for the TDC echo packer.
package tdc_echo_packer_pkg;

   localparam int REC_W    = 32;
   localparam int SID_W    = 8;
   localparam int CNT_W    = 2;
   localparam int INT_W    = 5;
   localparam int TOF_W    = 10;
   localparam int SUM_W    = 7;
   localparam int MAX_ECHO = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_DROP = 2'd2
   } pk_state_e;

   // MSB-first: {shot_id, cnt, pk_int, pk_tof, sum_int}
   typedef struct packed {
      logic [SID_W-1:0] shot_id;
      logic [CNT_W-1:0] cnt;
      logic [INT_W-1:0] pk_int;
      logic [TOF_W-1:0] pk_tof;
      logic [SUM_W-1:0] sum_int;
   } rec_t;

endpackage

// File: rtl/tdc_echo_packer_if.sv
// Echo beat stream in and packed record stream out of the TDC echo packer.
interface tdc_echo_packer_if;
   import tdc_echo_packer_pkg::*;

   logic [TOF_W-1:0] s_tdata;
   logic [INT_W-1:0] s_tint;
   logic             s_tlast;
   logic             s_tvalid;
   logic             s_tready;
   logic [REC_W-1:0] m_tdata;
   logic             m_tvalid;
   logic             m_tready;

   // slave: the packer itself; master: the surrounding TDC source and readout sink
   modport slave (
      input  s_tdata, s_tint, s_tlast, s_tvalid, m_tready,
      output s_tready, m_tdata, m_tvalid
   );

   modport master (
      output s_tdata, s_tint, s_tlast, s_tvalid, m_tready,
      input  s_tready, m_tdata, m_tvalid
   );

endinterface

// File: rtl/tdc_echo_packer_fifo.sv
// Synchronous first-word-fall-through record FIFO with occupancy level.
module tdc_echo_packer_fifo
   import tdc_echo_packer_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_i,
   input  logic [REC_W-1:0]         wdata_i,
   input  logic                     rd_i,
   output logic [REC_W-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   lvl_o
);
   localparam int AW    = $clog2(DEPTH);
   localparam int LVL_W = AW + 1;

   logic [REC_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
   logic [LVL_W-1:0] lvl_q, lvl_d;
   logic             wr_ok, rd_ok;

   assign empty_o = (lvl_q == '0);
   assign full_o  = (lvl_q == LVL_W'(DEPTH));
   assign rd_ok   = rd_i & ~empty_o;
   // A write into a full FIFO is legal when the same cycle frees an entry.
   assign wr_ok   = wr_i & (~full_o | rd_ok);

   always_comb begin
      wp_d  = wr_ok ? wp_q + 1'b1 : wp_q;
      rp_d  = rd_ok ? rp_q + 1'b1 : rp_q;
      lvl_d = lvl_q + LVL_W'(wr_ok) - LVL_W'(rd_ok);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wp_q  <= '0;
         rp_q  <= '0;
         lvl_q <= '0;
      end else begin
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         lvl_q <= lvl_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) mem_q[wp_q] <= wdata_i;
   end

   assign rdata_o = empty_o ? '0 : mem_q[rp_q];
   assign lvl_o   = lvl_q;

endmodule

// File: rtl/tdc_echo_packer.sv
// Packs 1..3-beat TDC echo bursts (and empty shots) into 32-bit records queued in a FIFO.
// Build option: TDC_PACK_INT_FILTER_EN skips counting beats with intensity below INT_MIN.
module tdc_echo_packer
   import tdc_echo_packer_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int INT_MIN    = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   tdc_echo_packer_if.slave             bus,
   input  logic                         shot_tick,
   input  logic                         clr_err,
   output logic                         burst_err,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_lvl
);
`ifdef TDC_PACK_INT_FILTER_EN
   localparam bit FILT_EN = 1'b1;
`else
   localparam bit FILT_EN = 1'b0;
`endif
   localparam logic [INT_W-1:0] INT_MIN_C = INT_MIN[INT_W-1:0];

   pk_state_e        st_q, st_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic [CNT_W-1:0] nbeat_q, nbeat_d, nbeat_inc;
   logic [INT_W-1:0] pk_int_q, pk_int_d, pk_int_inc;
   logic [TOF_W-1:0] pk_tof_q, pk_tof_d, pk_tof_inc;
   logic [SUM_W-1:0] sum_q, sum_d, sum_inc;
   logic [SID_W-1:0] shot_id_q, shot_id_d;
   logic             tick_pend_q, tick_pend_d;
   logic             seen_q, seen_d;
   logic             burst_err_q, burst_err_d;
   logic             beat, counted, burst_push, force_close, tick_do, empty_push;
   logic             fifo_wr, fifo_full, fifo_empty;
   logic [REC_W-1:0] fifo_rdata;
   rec_t             rec;

   assign bus.s_tready = ~rst & ~fifo_full;
   assign beat         = bus.s_tvalid & bus.s_tready;
   assign counted      = ~FILT_EN | (bus.s_tint >= INT_MIN_C);

   // Accumulator values as they would stand including the current beat.
   always_comb begin
      cnt_inc    = cnt_q;
      sum_inc    = sum_q;
      pk_int_inc = pk_int_q;
      pk_tof_inc = pk_tof_q;
      nbeat_inc  = nbeat_q + 1'b1;
      if (counted) begin
         if (cnt_q != CNT_W'(MAX_ECHO)) cnt_inc = cnt_q + 1'b1;
         sum_inc = sum_q + SUM_W'(bus.s_tint);
         if ((cnt_q == '0) || (bus.s_tint > pk_int_q)) begin
            pk_int_inc = bus.s_tint;
            pk_tof_inc = bus.s_tdata;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) st_q <= ST_IDLE;
      else     st_q <= st_d;
   end

   always_comb begin
      st_d = st_q;
      case (st_q)
         ST_IDLE: if (beat && !bus.s_tlast) st_d = ST_ACC;
         ST_ACC:  if (burst_push) st_d = force_close ? ST_DROP : ST_IDLE;
         ST_DROP: if (beat && bus.s_tlast) st_d = ST_IDLE;
         default: st_d = ST_IDLE;
      endcase
   end

   always_comb begin
      burst_push  = 1'b0;
      force_close = 1'b0;
      if (beat && (st_q != ST_DROP) &&
          (bus.s_tlast || (nbeat_inc == CNT_W'(MAX_ECHO)))) begin
         burst_push  = 1'b1;
         force_close = ~bus.s_tlast;
      end
      // A shot tick is only resolved in IDLE with FIFO room and no burst push competing.
      tick_do     = (shot_tick | tick_pend_q) & (st_q == ST_IDLE) & ~fifo_full & ~burst_push;
      empty_push  = tick_do & ~seen_q;
      fifo_wr     = burst_push | empty_push;
      rec         = '0;
      rec.shot_id = shot_id_q;
      if (burst_push) begin
         rec.cnt     = cnt_inc;
         rec.pk_int  = pk_int_inc;
         rec.pk_tof  = pk_tof_inc;
         rec.sum_int = sum_inc;
      end
   end

   always_comb begin
      cnt_d    = cnt_q;
      nbeat_d  = nbeat_q;
      pk_int_d = pk_int_q;
      pk_tof_d = pk_tof_q;
      sum_d    = sum_q;
      if (beat && (st_q != ST_DROP)) begin
         if (burst_push) begin
            cnt_d    = '0;
            nbeat_d  = '0;
            pk_int_d = '0;
            pk_tof_d = '0;
            sum_d    = '0;
         end else begin
            cnt_d    = cnt_inc;
            nbeat_d  = nbeat_inc;
            pk_int_d = pk_int_inc;
            pk_tof_d = pk_tof_inc;
            sum_d    = sum_inc;
         end
      end
      shot_id_d   = fifo_wr ? shot_id_q + 1'b1 : shot_id_q;
      tick_pend_d = (shot_tick | tick_pend_q) & ~tick_do;
      seen_d      = burst_push | (seen_q & ~tick_do);
      burst_err_d = clr_err ? 1'b0 : (burst_err_q | force_close);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q       <= '0;
         nbeat_q     <= '0;
         pk_int_q    <= '0;
         pk_tof_q    <= '0;
         sum_q       <= '0;
         shot_id_q   <= '0;
         tick_pend_q <= 1'b0;
         seen_q      <= 1'b0;
         burst_err_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         nbeat_q     <= nbeat_d;
         pk_int_q    <= pk_int_d;
         pk_tof_q    <= pk_tof_d;
         sum_q       <= sum_d;
         shot_id_q   <= shot_id_d;
         tick_pend_q <= tick_pend_d;
         seen_q      <= seen_d;
         burst_err_q <= burst_err_d;
      end
   end

   tdc_echo_packer_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_i    (fifo_wr),
      .wdata_i (rec),
      .rd_i    (bus.m_tready),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .lvl_o   (fifo_lvl)
   );

   assign bus.m_tdata  = fifo_rdata;
   assign bus.m_tvalid = ~fifo_empty;
   assign burst_err    = burst_err_q;

endmodule

// File: tb/tb_tdc_echo_packer.sv
// Directed bench for tdc_echo_packer: bursts, empty shots, back-pressure, overlong bursts, reset.
module tb_tdc_echo_packer;

   logic       clk = 1'b0;
   logic       rst;
   logic       shot_tick;
   logic       clr_err;
   logic       burst_err;
   logic [3:0] fifo_lvl;
   int         n_tests = 0;
   int         n_fail  = 0;

   always #2 clk = ~clk;

   tdc_echo_packer_if bus ();

   tdc_echo_packer #(
      .FIFO_DEPTH (8),
      .INT_MIN    (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .shot_tick (shot_tick),
      .clr_err   (clr_err),
      .burst_err (burst_err),
      .fifo_lvl  (fifo_lvl)
   );

   function automatic logic [31:0] rec(input int sid, input int cnt, input int pki,
                                       input int tof, input int sum);
      return {sid[7:0], cnt[1:0], pki[4:0], tof[9:0], sum[6:0]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive one beat from a negedge and return on the negedge after its handshake.
   task automatic send_beat(input logic [9:0] tof, input logic [4:0] ti, input logic last);
      int n;
      n = 0;
      bus.s_tdata  = tof;
      bus.s_tint   = ti;
      bus.s_tlast  = last;
      bus.s_tvalid = 1'b1;
      while (!bus.s_tready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("beat_ready", 32'(bus.s_tready), 32'd1);
      @(negedge clk);
      bus.s_tvalid = 1'b0;
      bus.s_tlast  = 1'b0;
   endtask

   task automatic pop_check(input string tag, input logic [31:0] exp);
      int n;
      n = 0;
      while (!bus.m_tvalid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_vld"}, 32'(bus.m_tvalid), 32'd1);
      chk(tag, bus.m_tdata, exp);
      bus.m_tready = 1'b1;
      @(negedge clk);
      bus.m_tready = 1'b0;
   endtask

   task automatic tick();
      shot_tick = 1'b1;
      @(negedge clk);
      shot_tick = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      rst          = 1'b1;
      shot_tick    = 1'b0;
      clr_err      = 1'b0;
      bus.s_tdata  = '0;
      bus.s_tint   = '0;
      bus.s_tlast  = 1'b0;
      bus.s_tvalid = 1'b0;
      bus.m_tready = 1'b0;
      repeat (3) @(negedge clk);

      chk("rst_tready", 32'(bus.s_tready), 32'd0);
      chk("rst_mvalid", 32'(bus.m_tvalid), 32'd0);
      chk("rst_mdata", bus.m_tdata, 32'd0);
      chk("rst_err", 32'(burst_err), 32'd0);
      chk("rst_lvl", 32'(fifo_lvl), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_tready", 32'(bus.s_tready), 32'd1);

      // Single-beat burst, record checked against a hand-packed constant.
      send_beat(10'h155, 5'd7, 1'b1);
      chk("single_lvl", 32'(fifo_lvl), 32'd1);
      pop_check("single_rec", 32'h004E_AA87);
      chk("single_empty", 32'(bus.m_tvalid), 32'd0);

      // Three beats with a peak tie: the earlier echo keeps the peak.
      send_beat(10'd10, 5'd5, 1'b0);
      send_beat(10'd20, 5'd9, 1'b0);
      send_beat(10'd30, 5'd9, 1'b1);
      pop_check("three_rec", rec(1, 3, 9, 20, 23));

      // First tick closes the window that had bursts; the next two are empty shots.
      tick();
      chk("burst_shot_no_rec", 32'(fifo_lvl), 32'd0);
      tick();
      tick();
      chk("empty_lvl", 32'(fifo_lvl), 32'd2);
      pop_check("empty_rec0", 32'h0200_0000);
      pop_check("empty_rec1", 32'h0300_0000);

      // Fill the FIFO with 8 records while the sink stalls.
      for (int k = 0; k < 8; k++) send_beat(10'(16 * k + 1), 5'(k + 1), 1'b1);
      chk("full_lvl", 32'(fifo_lvl), 32'd8);
      chk("full_tready", 32'(bus.s_tready), 32'd0);
      chk("full_head", bus.m_tdata, rec(4, 1, 1, 1, 1));
      bus.s_tdata  = 10'(16 * 8 + 1);
      bus.s_tint   = 5'd9;
      bus.s_tlast  = 1'b1;
      bus.s_tvalid = 1'b1;
      repeat (3) @(negedge clk);
      chk("stall_lvl", 32'(fifo_lvl), 32'd8);
      chk("stall_tready", 32'(bus.s_tready), 32'd0);
      chk("stall_head", bus.m_tdata, rec(4, 1, 1, 1, 1));
      bus.m_tready = 1'b1;
      @(negedge clk);
      bus.m_tready = 1'b0;
      chk("freed_lvl", 32'(fifo_lvl), 32'd7);
      chk("freed_tready", 32'(bus.s_tready), 32'd1);
      @(negedge clk);
      bus.s_tvalid = 1'b0;
      bus.s_tlast  = 1'b0;
      chk("ninth_lvl", 32'(fifo_lvl), 32'd8);
      for (int k = 1; k < 9; k++)
         pop_check("drain_rec", rec(4 + k, 1, k + 1, 16 * k + 1, k + 1));
      chk("drain_lvl", 32'(fifo_lvl), 32'd0);

      // Overlong burst: force-closed on beat 3, beat 4 dropped.
      send_beat(10'd100, 5'd3, 1'b0);
      send_beat(10'd200, 5'd8, 1'b0);
      send_beat(10'd300, 5'd2, 1'b0);
      chk("long_err", 32'(burst_err), 32'd1);
      chk("long_rec", bus.m_tdata, rec(13, 3, 8, 200, 13));
      send_beat(10'd400, 5'd15, 1'b1);
      chk("long_lvl", 32'(fifo_lvl), 32'd1);
      chk("long_hold", bus.m_tdata, rec(13, 3, 8, 200, 13));
      pop_check("long_pop", rec(13, 3, 8, 200, 13));
      chk("long_no_extra", 32'(bus.m_tvalid), 32'd0);
      chk("err_sticky", 32'(burst_err), 32'd1);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      chk("err_cleared", 32'(burst_err), 32'd0);

      // Reset in the middle of a burst discards it and restarts shot_id.
      send_beat(10'd5, 5'd4, 1'b0);
      send_beat(10'd6, 5'd6, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_tready", 32'(bus.s_tready), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_mvalid", 32'(bus.m_tvalid), 32'd0);
      chk("midrst_lvl", 32'(fifo_lvl), 32'd0);
      send_beat(10'h3FF, 5'd16, 1'b1);
      pop_check("midrst_rec", rec(0, 1, 16, 10'h3FF, 16));

      // Low-intensity first beat: skipped by the filter build, counted otherwise.
      send_beat(10'd11, 5'd1, 1'b0);
      send_beat(10'd22, 5'd4, 1'b1);
`ifdef TDC_PACK_INT_FILTER_EN
      pop_check("filt_rec", rec(1, 1, 4, 22, 4));
`else
      pop_check("filt_rec", rec(1, 2, 4, 22, 5));
`endif
      chk("final_mvalid", 32'(bus.m_tvalid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
